// File: rtl/pipe_cla_pkg.sv
// rtl/pipe_cla_pkg.sv - shared types, defaults and stage-count helper for the pipelined CLA adder
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_BLK_W  default operand width and bits resolved per stage
//   stage_ctl_t                    per-stage valid flag and registered block carry-out
//   num_blk()                      number of lookahead blocks (= pipeline stages)
package pipe_cla_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_BLK_W = 8;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int num_blk(input int width, input int blk_w);
        return width / blk_w;
    endfunction

endpackage

// File: rtl/pipe_cla_adder_if.sv
// rtl/pipe_cla_adder_if.sv - operand/result handshake bundle for pipe_cla_adder
//
// Signals:
//   in_valid/in_ready    operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready  result handshake (sum, cout, and ovf when PIPE_CLA_OVF_EN is defined)
// Modports:
//   master  drives operands and out_ready (upstream/downstream side)
//   slave   the adder itself
// Optional: `define PIPE_CLA_OVF_EN adds the ovf result signal.
interface pipe_cla_adder_if
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_CLA_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLK_W-bit carry-lookahead adder block
//
// Ports:
//   a, b   BLK_W-bit operands (b already inverted by the caller for subtraction)
//   cin    carry into bit 0
//   sum    BLK_W-bit sum
//   cout   carry out of bit BLK_W-1
//   c_msb  carry into bit BLK_W-1 (used for signed overflow)
module cla_block #(
    parameter int BLK_W = 8
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;
    logic             gen_acc;
    logic             prop_acc;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat sum-of-products over all lower generates,
    // not a chain through c[i], so every carry is two logic levels deep.
    always_comb begin
        c        = '0;
        gen_acc  = 1'b0;
        prop_acc = 1'b1;
        c[0]     = cin;
        for (int i = 0; i < BLK_W; i++) begin
            gen_acc  = 1'b0;
            prop_acc = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gen_acc  = gen_acc | (g[j] & prop_acc);
                prop_acc = prop_acc & p[j];
            end
            c[i+1] = gen_acc | (prop_acc & cin);
        end
    end

    assign sum   = p ^ c[BLK_W-1:0];
    assign cout  = c[BLK_W];
    assign c_msb = c[BLK_W-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one BLK_W block per stage
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_cla_adder_if.slave: in_valid/in_ready, a, b, cin, sub,
//          out_valid/out_ready, sum, cout (+ ovf)
// Optional: `define PIPE_CLA_OVF_EN adds the registered signed-overflow output bus.ovf.
// Latency is WIDTH/BLK_W cycles; throughput one beat per cycle; the whole
// pipeline freezes while a result is waiting on out_ready.
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLK_W = DEFAULT_BLK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_cla_adder_if.slave   bus
);

    localparam int NUM_BLK = num_blk(WIDTH, BLK_W);
    localparam int LAST    = NUM_BLK - 1;

    logic               advance;
    logic [NUM_BLK-1:0] cmsb_all;
    logic               unused_cmsb;

    for (genvar k = 0; k < NUM_BLK; k++) begin : stage
        // Operand bits not yet consumed on entry to this stage; the block
        // eats the low BLK_W of them, the rest ride the skew registers.
        localparam int IN_W = WIDTH - k * BLK_W;
        localparam int LO_W = k * BLK_W;

        logic [IN_W-1:0]       in_a;
        logic [IN_W-1:0]       in_b;
        logic                  in_valid;
        logic                  in_cin;
        logic [LO_W+BLK_W-1:0] sum_nxt;
        logic [BLK_W-1:0]      blk_sum;
        logic                  blk_cout;
        logic                  blk_cmsb;
        stage_ctl_t            ctl_q;
        logic [LO_W+BLK_W-1:0] sum_q;

        if (k == 0) begin : g_first
            assign in_a     = bus.a;
            assign in_b     = bus.sub ? ~bus.b : bus.b;
            assign in_cin   = bus.sub | bus.cin;
            assign in_valid = bus.in_valid;
            assign sum_nxt  = blk_sum;
        end else begin : g_next
            assign in_a     = stage[k-1].g_skew.a_q;
            assign in_b     = stage[k-1].g_skew.b_q;
            assign in_cin   = stage[k-1].ctl_q.carry;
            assign in_valid = stage[k-1].ctl_q.valid;
            assign sum_nxt  = {blk_sum, stage[k-1].sum_q};
        end

        cla_block #(
            .BLK_W (BLK_W)
        ) u_blk (
            .a     (in_a[BLK_W-1:0]),
            .b     (in_b[BLK_W-1:0]),
            .cin   (in_cin),
            .sum   (blk_sum),
            .cout  (blk_cout),
            .c_msb (blk_cmsb)
        );

        assign cmsb_all[k] = blk_cmsb;

        // Data registers load on bubbles too; only ctl_q.valid qualifies them.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else if (advance) begin
                ctl_q.valid <= in_valid;
                ctl_q.carry <= blk_cout;
                sum_q       <= sum_nxt;
            end
        end

        if (k < LAST) begin : g_skew
            logic [IN_W-BLK_W-1:0] a_q;
            logic [IN_W-BLK_W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= in_a[IN_W-1:BLK_W];
                    b_q <= in_b[IN_W-1:BLK_W];
                end
            end
        end
    end

    // Only the top block's MSB carry matters (and only for ovf).
    assign unused_cmsb = ^cmsb_all;

    assign advance       = !stage[LAST].ctl_q.valid || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = stage[LAST].ctl_q.valid;
    assign bus.sum       = stage[LAST].sum_q;
    assign bus.cout      = stage[LAST].ctl_q.carry;

`ifdef PIPE_CLA_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= stage[LAST].blk_cmsb ^ stage[LAST].blk_cout;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - self-checking bench for pipe_cla_adder (honours PIPE_CLA_OVF_EN)
module tb_pipe_cla_adder;
    import pipe_cla_pkg::*;

    localparam int WIDTH = 32;
    localparam int BLK_W = 8;
    localparam int LAT   = WIDTH / BLK_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipe_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_cla_adder #(
        .WIDTH (WIDTH),
        .BLK_W (BLK_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] q_sum[$];
    logic             q_cout[$];
    logic             q_ovf[$];

    logic             o_valid;
    logic             o_inrdy;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic             acc;
    logic             drn;
    logic [WIDTH-1:0] exp_s;
    logic             exp_c;
    logic             exp_o;

    // Reference: plain (WIDTH+1)-bit arithmetic plus the sign rule for overflow.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        logic             carry;
        logic             ovf;
        bb    = sub ? ~b : b;
        carry = sub ? 1'b1 : cin;
        full  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, carry};
        ovf   = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full};
    endfunction

    // One cycle: drive at negedge, observe 1 time unit later, log accepted beats.
    task automatic step(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic ordy);
        logic [WIDTH+1:0] m;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.out_ready = ordy;
        #1;
        o_valid = bus.out_valid;
        o_inrdy = bus.in_ready;
        o_sum   = bus.sum;
        o_cout  = bus.cout;
`ifdef PIPE_CLA_OVF_EN
        o_ovf   = bus.ovf;
`else
        o_ovf   = 1'b0;
`endif
        acc = iv && o_inrdy;
        drn = o_valid && ordy;
        if (acc) begin
            m = model(a, b, cin, sub);
            q_sum.push_back(m[WIDTH-1:0]);
            q_cout.push_back(m[WIDTH]);
            q_ovf.push_back(m[WIDTH+1]);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        vectors++;
        if (bus.sum !== '0) begin miscompares++; $display("FAIL reset_sum: got %h, expected 0", bus.sum); end
        vectors++;
        if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b, expected 0", bus.cout); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
`ifdef PIPE_CLA_OVF_EN
        vectors++;
        if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b, expected 0", bus.ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000};
        logic [WIDTH-1:0] tb_ [4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0007, 32'h0000_0001};
        logic             tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic             ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] es [4] = '{32'h0000_0003, 32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
        logic             ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic             eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int n_out;
        int first_out;
        n_out     = 0;
        first_out = -1;
        for (int s = 0; s < 16; s++) begin
            if (s < 4) step(1'b1, ta[s], tb_[s], tc[s], ts[s], 1'b1);
            else       step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (drn) begin
                if (first_out < 0) first_out = s;
                void'(q_sum.pop_front());
                void'(q_cout.pop_front());
                void'(q_ovf.pop_front());
                if (n_out < 4) begin
                    vectors++;
                    if (o_sum !== es[n_out] || o_cout !== ec[n_out]) begin
                        miscompares++;
                        $display("FAIL directed_%0d: got sum=%h cout=%b, expected sum=%h cout=%b",
                                 n_out, o_sum, o_cout, es[n_out], ec[n_out]);
                    end
`ifdef PIPE_CLA_OVF_EN
                    vectors++;
                    if (o_ovf !== eo[n_out]) begin
                        miscompares++;
                        $display("FAIL directed_ovf_%0d: got %b, expected %b", n_out, o_ovf, eo[n_out]);
                    end
`endif
                end
                n_out++;
            end
        end
        vectors++;
        if (first_out != LAT) begin miscompares++; $display("FAIL latency: got %0d cycles, expected %0d", first_out, LAT); end
        vectors++;
        if (n_out != 4) begin miscompares++; $display("FAIL directed_count: got %0d results, expected 4", n_out); end
    endtask

    task automatic test_back_to_back();
        int sent;
        int recv;
        logic [WIDTH-1:0] held;
        logic             ordy;
        sent = 0;
        recv = 0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            ordy = !(c >= 6 && c <= 9);
            step(sent < 8, WIDTH'(sent), WIDTH'(sent * 32'h100), 1'b0, 1'b0, ordy);
            if (acc) sent++;
            if (c >= 6 && c <= 9) begin
                vectors++;
                if (o_valid !== 1'b1 || o_inrdy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_ready: cycle %0d got out_valid=%b in_ready=%b, expected 1/0", c, o_valid, o_inrdy);
                end
                if (c == 6) held = o_sum;
                else begin
                    vectors++;
                    if (o_sum !== held) begin miscompares++; $display("FAIL stall_hold: cycle %0d got %h, expected %h", c, o_sum, held); end
                end
            end
            if (drn) begin
                vectors++;
                if (q_sum.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_spurious: got sum=%h, expected no result", o_sum);
                end else begin
                    exp_s = q_sum.pop_front();
                    exp_c = q_cout.pop_front();
                    exp_o = q_ovf.pop_front();
                    if (o_sum !== exp_s || o_cout !== exp_c || o_sum !== WIDTH'(recv * 32'h101)) begin
                        miscompares++;
                        $display("FAIL b2b_result_%0d: got sum=%h cout=%b, expected sum=%h cout=%b", recv, o_sum, o_cout, exp_s, exp_c);
                    end
                end
                recv++;
            end
        end
        vectors++;
        if (recv != 8 || q_sum.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results with %0d pending, expected 8 and 0", recv, q_sum.size());
        end
    endtask

    task automatic test_alternating();
        logic expv;
        for (int c = 0; c < 16; c++) begin
            step((c < 8) && (c % 2 == 0), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'b1);
            expv = (c >= LAT) && (c - LAT < 8) && ((c - LAT) % 2 == 0);
            vectors++;
            if (o_valid !== expv) begin miscompares++; $display("FAIL alt_valid: cycle %0d got %b, expected %b", c, o_valid, expv); end
            if (drn && q_sum.size() != 0) begin
                exp_s = q_sum.pop_front();
                exp_c = q_cout.pop_front();
                exp_o = q_ovf.pop_front();
                vectors++;
                if (o_sum !== exp_s || o_cout !== exp_c) begin
                    miscompares++;
                    $display("FAIL alt_result: got sum=%h cout=%b, expected sum=%h cout=%b", o_sum, o_cout, exp_s, exp_c);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        for (int c = 0; c < 340; c++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'hFFFF_FFFF;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'h7FFF_FFFF;
                default: ra = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 32'h0000_0000;
                1:       rb = 32'hFFFF_FFFF;
                default: rb = WIDTH'($urandom);
            endcase
            step((c < 300) && ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
                 (c >= 300) || ($urandom_range(0, 3) != 0));
            if (drn) begin
                vectors++;
                if (q_sum.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_spurious: got sum=%h, expected no result", o_sum);
                end else begin
                    exp_s = q_sum.pop_front();
                    exp_c = q_cout.pop_front();
                    exp_o = q_ovf.pop_front();
                    if (o_sum !== exp_s || o_cout !== exp_c) begin
                        miscompares++;
                        $display("FAIL rand_result: got sum=%h cout=%b, expected sum=%h cout=%b", o_sum, o_cout, exp_s, exp_c);
                    end
`ifdef PIPE_CLA_OVF_EN
                    vectors++;
                    if (o_ovf !== exp_o) begin miscompares++; $display("FAIL rand_ovf: got %b, expected %b", o_ovf, exp_o); end
`endif
                end
            end
        end
        vectors++;
        if (q_sum.size() != 0) begin miscompares++; $display("FAIL rand_drain: got %0d pending, expected 0", q_sum.size()); end
    endtask

    task automatic test_reset_midflight();
        for (int s = 0; s < 5; s++) begin
            step(s < 3, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
        end
        vectors++;
        if (o_valid !== 1'b1) begin miscompares++; $display("FAIL mid_prefill: got out_valid=%b, expected 1", o_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.sum !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got out_valid=%b sum=%h, expected 0/0", bus.out_valid, bus.sum);
        end
        q_sum.delete();
        q_cout.delete();
        q_ovf.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 10; s++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale: cycle %0d got out_valid=1 sum=%h, expected 0", s, o_sum); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_alternating();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
Name: pipe_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into NUM_BLK = WIDTH/BLK_W lookahead blocks, evaluating one block per pipeline stage with a registered carry between stages.
- Valid/ready handshake on both sides, so it drops into datapaths that need wide adds at high clock rates. Successor to the fixed 4-bit combinational lookahead adder.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLK_W.
- BLK_W, 8, bits resolved per stage by one lookahead block; 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry/borrow-in (ignored when sub=1)
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry-out of MSB (for sub: 1 = no borrow)

Behaviour:
- Reset: clk and rst_n are the single clock and the asynchronous active-low reset. Reset clears every stage valid, carry, and data register. Outputs after reset: out_valid=0, sum=0, cout=0, in_ready=1.
- Pipeline: NUM_BLK stages. Stage k (0-based) adds bits [k*BLK_W +: BLK_W] using generate/propagate lookahead, with carry-in from stage k-1's registered carry.
  - Stage 0 carry-in = sub ? 1 : cin; B is inverted when sub=1.
  - Upper unprocessed operand bits and already-computed lower sum bits travel with the beat in skew registers.
- Latency: exactly NUM_BLK cycles from in_valid&&in_ready to out_valid, when no stall occurs. Throughput is 1 beat/cycle.
- Advance/stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, all stages hold, and sum/cout stay stable while out_valid=1.
  - Bubbles are not collapsed during a stall; the stage valid bits shift only on advance.
- Simultaneous accept and drain in the same cycle is legal and loses no beat.
- NUM_BLK=1 (BLK_W=WIDTH): one registered stage, latency 1.
- in_valid=0 on an advance inserts a bubble. That stage's valid=0, and its data registers may hold don't-care values.
- Reset asserted mid-operation discards all in-flight beats immediately. out_valid drops asynchronously.
- Width rule: cout is the carry out of bit WIDTH-1; there is no internal overflow saturation.

Optional Feature:
- Macro: PIPE_CLA_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf is pipelined alongside sum, reset to 0, and valid only with out_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_cla_pkg:
  - function num_blk(WIDTH, BLK_W);
  - typedef for the per-stage carry/valid bundle;
  - localparam defaults for WIDTH and BLK_W.
- Sub-module cla_block (combinational, parameter BLK_W): inputs a, b, cin; outputs sum, cout, and the carry into the MSB (for the overflow feature). It is instantiated once per stage.

Test Plan (WIDTH=32, BLK_W=8, latency 4):
- Reset release, a=0x0000_0001, b=0x0000_0002, cin=0, sub=0 -> out_valid after 4 cycles, sum=0x0000_0003, cout=0.
- a=0xFFFF_FFFF, b=0x0000_0000, cin=1 (full ripple across all blocks) -> sum=0x0000_0000, cout=1; with PIPE_CLA_OVF_EN, ovf=0.
- sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0. Then a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-to-back beats i=0..7 (a=i, b=0x100*i), out_ready held 0 for cycles 6-9 -> in_ready=0 during the stall, out_valid/sum held stable, then all 8 results emitted in order with none lost or duplicated.
- Alternating in_valid (1,0,1,0) with out_ready=1 -> out_valid follows the same 1,0,1,0 pattern delayed by 4 cycles.
- rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, and no stale result appears after reset release.
